// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO in front of it.
// Frames: start bit, DATA_BITS data bits (LSB first), optional parity, 1 or 2 stop bits.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset
//   din        - byte to enqueue
//   wr         - enqueue strobe
//   parity_en  - 1 = append parity bit
//   parity_odd - 1 = odd parity, 0 = even
//   stop2      - 1 = two stop bits, 0 = one
//   tx         - serial line, idle high, registered
//   bsy        - FSM active or FIFO non-empty
//   full       - FIFO holds FIFO_DEPTH entries
//   empty      - FIFO holds no entries
//   level      - FIFO occupancy
//   ovf        - sticky, a write was dropped while full
module uart_tx_fifo #(
    parameter int CLK_HZ     = 40000000,
    parameter int BAUD       = 921600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          wr,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop2,
    output logic                          tx,
    output logic                          bsy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(2 * DIV);

    // ------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------
    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_fifo: CLK_HZ/BAUD must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
            $error("uart_tx_fifo: DATA_BITS must be 5..8");
        end
        if (FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wp;
    logic [AW-1:0]        r_rp;
    logic [AW:0]          r_level;
    logic                 r_ovf;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_max;
    logic                 w_cnt_end;
    logic [2:0]           r_bit;
    logic                 w_last_bit;
    logic [DATA_BITS-1:0] r_shr;
    logic                 r_par;
    logic                 r_pen;
    logic                 r_s2;
    logic                 r_tx;
    logic                 w_tx_nxt;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    // ------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------
    assign w_full  = (r_level == (AW + 1)'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    // A write while full is dropped even if the FSM pops this cycle.
    assign w_push  = wr & ~w_full;
    assign w_pop   = (r_state == S_IDLE) & ~w_empty;
    assign w_head  = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (wr && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------
    // Bit timing
    // ------------------------------------------------------------
    // Two stop bits are timed as one double-length period.
    assign w_cnt_max  = (r_state == S_STOP && r_s2) ?
                        CW'(2 * DIV - 1) : CW'(DIV - 1);
    assign w_cnt_end  = (r_cnt == w_cnt_max);
    assign w_last_bit = (r_bit == 3'(DATA_BITS - 1));

    // ------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_cnt_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_cnt_end && w_last_bit) begin
                    w_state_nxt = r_pen ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_cnt_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_cnt_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------
    // FSM: output
    // ------------------------------------------------------------
    always_comb begin
        w_tx_nxt = 1'b1;
        unique case (r_state)
            S_IDLE:   w_tx_nxt = 1'b1;
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_shr[0];
            S_PARITY: w_tx_nxt = r_par;
            S_STOP:   w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // ------------------------------------------------------------
    // Datapath: counters, shift register, latched frame modes
    // ------------------------------------------------------------
    // tx is re-registered from the state, so the line lags the
    // FSM by one clock; every bit keeps the same DIV length.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_bit <= '0;
            r_shr <= '0;
            r_par <= 1'b0;
            r_pen <= 1'b0;
            r_s2  <= 1'b0;
            r_tx  <= 1'b1;
        end else begin
            r_tx <= w_tx_nxt;
            if (w_pop) begin
                r_shr <= w_head;
                r_par <= (^w_head) ^ parity_odd;
                r_pen <= parity_en;
                r_s2  <= stop2;
                r_cnt <= '0;
                r_bit <= '0;
            end else if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (w_cnt_end) begin
                r_cnt <= '0;
                if (r_state == S_DATA) begin
                    r_shr <= r_shr >> 1;
                    r_bit <= w_last_bit ? 3'd0 : 3'(r_bit + 3'd1);
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------
    assign tx    = r_tx;
    assign bsy   = (r_state != S_IDLE) | ~w_empty;
    assign full  = w_full;
    assign empty = w_empty;
    assign level = r_level;
    assign ovf   = r_ovf;

endmodule
